// File: rtl/ex_pkg.sv
// Purpose: shared ALUOp/funct encodings and ALU control type for the execute stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ex_pkg;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  // R-type funct field values (instruction bits [5:0])
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, NOR, SLT, NOP} alu_ctl_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational integer ALU (add/sub/and/or/xor/nor/signed slt, NOP -> 0).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: ctl (operation), a/b (DW-bit operands) -> result (DW), zero (result == 0).
module alu_core
  import ex_pkg::*;
#(
  parameter int DW = 32
) (
  input  alu_ctl_t        ctl,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (ctl)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      NOR:     result = ~(a | b);
      SLT:     result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Purpose: execute stage - operand forwarding, ALU control decode, ALU, dst select, EX/MEM register.
// Latency: one cycle from ID/EX inputs to EX/MEM outputs.
// Backpressure: stall holds the EX/MEM register; flush loads a bubble and wins over stall.
// Ports: clk/rst (async, active-high); stall/flush; ex_* ID/EX control+data; wb_* MEM/WB
//        forward source; mem_* registered EX/MEM bundle (result, store data, dst, zero, control).
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    ex_alu_op,
  input  logic          ex_alu_src,
  input  logic          ex_reg_dst,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_reg_write,
  input  logic [DW-1:0] ex_rd1,
  input  logic [DW-1:0] ex_rd2,
  input  logic [DW-1:0] ex_imm,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_rd,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] mem_alu_result,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_dst,
  output logic          mem_zero,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_mem_to_reg,
  output logic          mem_reg_write
);

  typedef struct packed {
    logic [DW-1:0] alu_result;
    logic [DW-1:0] store_data;
    logic [RW-1:0] dst;
    logic          zero;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_write;
  } exmem_t;

  exmem_t        q;
  exmem_t        d;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  alu_ctl_t      alu_ctl;

  // Forwarding reads the registered EX/MEM bundle, so a stalled stage forwards its held
  // values. Loads are excluded from EX/MEM forwarding: their alu_result is an address.
  always_comb begin
    fwd_rs = ex_rd1;
    if (q.reg_write && !q.mem_to_reg && (q.dst != '0) && (q.dst == ex_rs))
      fwd_rs = q.alu_result;
    else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs))
      fwd_rs = wb_data;
  end

  always_comb begin
    fwd_rt = ex_rd2;
    if (q.reg_write && !q.mem_to_reg && (q.dst != '0) && (q.dst == ex_rt))
      fwd_rt = q.alu_result;
    else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt))
      fwd_rt = wb_data;
  end

  // ORI uses the zero-extended low half of the immediate, not the sign-extended value.
  always_comb begin
    if (ex_alu_op == ALUOP_ORI)
      op_b = {{(DW-16){1'b0}}, ex_imm[15:0]};
    else if (ex_alu_src)
      op_b = ex_imm;
    else
      op_b = fwd_rt;
  end

  always_comb begin
    alu_ctl = NOP;
    case (ex_alu_op)
      ALUOP_ADD: alu_ctl = ADD;
      ALUOP_SUB: alu_ctl = SUB;
      ALUOP_ORI: alu_ctl = OR;
      ALUOP_RTYPE: begin
        case (ex_imm[5:0])
          FUNCT_ADD, FUNCT_ADDU: alu_ctl = ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctl = SUB;
          FUNCT_AND:             alu_ctl = AND;
          FUNCT_OR:              alu_ctl = OR;
          FUNCT_XOR:             alu_ctl = XOR;
          FUNCT_NOR:             alu_ctl = NOR;
          FUNCT_SLT:             alu_ctl = SLT;
          default:               alu_ctl = NOP;
        endcase
      end
      default: alu_ctl = NOP;
    endcase
  end

  alu_core #(.DW(DW)) u_alu (
    .ctl    (alu_ctl),
    .a      (fwd_rs),
    .b      (op_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    d            = '0;
    d.alu_result = alu_result;
    d.store_data = fwd_rt;
    d.dst        = ex_reg_dst ? ex_rd : ex_rt;
    d.zero       = alu_zero;
    d.mem_read   = ex_mem_read;
    d.mem_write  = ex_mem_write;
    d.mem_to_reg = ex_mem_to_reg;
    d.reg_write  = ex_reg_write;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (!stall)
      q <= d;
  end

  assign mem_alu_result = q.alu_result;
  assign mem_store_data = q.store_data;
  assign mem_dst        = q.dst;
  assign mem_zero       = q.zero;
  assign mem_mem_read   = q.mem_read;
  assign mem_mem_write  = q.mem_write;
  assign mem_mem_to_reg = q.mem_to_reg;
  assign mem_reg_write  = q.reg_write;

endmodule
